// File: rtl/load_store_unit.sv
// Load/store unit between a processor memory stage and a word-wide data RAM.
// Sub-word stores use read-modify-write; loads extract and extend the addressed lane.
module load_store_unit #(
    parameter int MEM_WORDS = 102
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nx;
    logic        we_q, sext_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] wdata_q, buf_q;
    logic        bad;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] load_val, merged;

    assign bad = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (addr >= ADDR_LIMIT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req) state_nx = bad ? DONE : ((!we || size != 2'b10) ? READ : WRITE);
            READ:  state_nx = we_q ? WRITE : DONE;
            WRITE: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lane8  = mem_RD[{lane_q, 3'b000} +: 8];
        lane16 = mem_RD[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane8[7]}}, lane8};
            2'b01:   load_val = {{16{sext_q & lane16[15]}}, lane16};
            default: load_val = mem_RD;
        endcase
        merged = buf_q;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata   <= '0;
            mem_A   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sign_ext;
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                err_q   <= bad;
                if (!bad) mem_A <= {addr[31:2], 2'b00};
            end
            if (state == READ) begin
                buf_q <= mem_RD;
                if (!we_q) rdata <= load_val;
            end
        end
    end

    // Write strobe is masked by rst so a reset landing in WRITE never reaches the RAM.
    assign mem_WE = (state == WRITE) && !rst;
    assign mem_WD = (size_q == 2'b10) ? wdata_q : merged;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign err    = done && err_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 102, number of 32-bit words in the downstream data RAM; valid byte addresses are 0 to 4*MEM_WORDS-1.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  1  access request from the processor memory stage; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  access width: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned in bits [7:0], [15:0] or [31:0].
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; marks a rejected access.
REQ-013 rdata  out  32  extended load result; held until the next accepted load.
REQ-014 mem_WE  out  1  RAM write enable.
REQ-015 mem_A  out  32  RAM byte address, always word-aligned.
REQ-016 mem_WD  out  32  RAM write data.
REQ-017 mem_RD  in  32  RAM read data; combinational from mem_A in the same cycle.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE.
REQ-019 IDLE with req=1: the unit latches we, size, sign_ext, addr and wdata; later input changes have no effect on this access.
REQ-020 An access is rejected if any of these holds: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; addr >= 4*MEM_WORDS.
REQ-021 Rejected access: IDLE -> DONE with err=1; no RAM write occurs and rdata is unchanged.
REQ-022 Accepted transitions: load IDLE->READ->DONE; word store IDLE->WRITE->DONE; byte or halfword store IDLE->READ->WRITE->DONE.
REQ-023 READ: mem_A={addr[31:2],2'b00}, mem_WE=0; the unit captures mem_RD into an internal word buffer at the end of the cycle.
REQ-024 WRITE: mem_WE=1 for exactly one cycle at the same mem_A. mem_WD is one of:
  - word store: wdata.
  - sub-word store: buffer with only the addressed lane replaced.
REQ-025 Lanes are little-endian.
  - byte lane = addr[1:0], bits [8*k+7:8*k].
  - halfword lane = addr[1], bits [16*h+15:16*h].
REQ-026 Load extraction uses the addressed lane, zero- or sign-extended per sign_ext; a word load returns mem_RD unchanged. rdata updates on entry to DONE.
REQ-027 DONE: done=1 for one cycle, then IDLE. req is ignored in READ, WRITE and DONE; a request held high through DONE is accepted in the following IDLE cycle.
REQ-028 Latency from the req-accept edge to done high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - rejected access: 1 cycle.
REQ-029 In IDLE and DONE: mem_WE=0 and mem_A holds the last access address (0 after reset).
REQ-030 err=0 whenever done=0.

Reset
REQ-031 rst=1 at a clock edge forces IDLE from any state, aborts an in-flight access with no done pulse, and clears busy, done, err, rdata, mem_WE, mem_A, mem_WD and the buffer to 0.
REQ-032 mem_WE is 0 during the reset cycle even if reset arrives in WRITE; no partial write is issued.

Verification
REQ-033 RAM word 3 = 0x11223344; load byte at addr 0x0E with sign_ext=1 -> done 2 cycles after accept, rdata=0x00000022, err=0.
REQ-034 Same word; store halfword 0xBEEF at addr 0x0C -> one write, mem_WE high exactly one cycle, mem_WD=0x1122BEEF at mem_A=0x0C, done 3 cycles after accept.
REQ-035 Load word at addr 0x06 -> done with err=1 one cycle after accept, mem_WE never asserted, rdata unchanged.
REQ-036 Store word at addr 408 (MEM_WORDS=102) -> err=1, no RAM write.
REQ-037 rst=1 during WRITE of a byte store -> mem_WE=0 that cycle, RAM word unchanged, no done pulse, next load returns the old value.
REQ-038 req held high for 6 cycles with a word load -> exactly two accepted loads, two done pulses 3 cycles apart, busy low only in the accept cycles.
